rca_bist: RTL and testbench

RCA_BIST -- requirements
Module: rca_bist

---
 rtl/rca_pkg.sv | 19 +
 rtl/rca_bist_opgen.sv | 52 +++++
 rtl/rca_bist.sv | 165 ++++++++++++++++
 tb/tb_rca_bist.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder BIST: FSM encoding and derived bus widths.
package rca_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int sum_width(input int w);
        return w + 1;
    endfunction

    function automatic int cnt_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/rca_bist_opgen.sv
// Exhaustive operand generator: b is the inner count, a the outer; flags the final (all-ones, all-ones) vector.
module rca_bist_opgen import rca_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             last_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    // Next operand pair: clear wins over advance; a steps only when b wraps
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (clr_i) begin
            a_d = '0;
            b_d = '0;
        end else if (adv_i) begin
            b_d = b_q + WIDTH'(1);
            if (&b_q) begin
                a_d = a_q + WIDTH'(1);
            end else begin
                a_d = a_q;
            end
        end else begin
            a_d = a_q;
            b_d = b_q;
        end
    end

    // Operand registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a_o    = a_q;
    assign b_o    = b_q;
    assign last_o = (&a_q) & (&b_q);

endmodule

// File: rtl/rca_bist.sv
// BIST controller that sweeps every operand pair through an external adder and logs mismatches.
module rca_bist import rca_pkg::*; #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1,
    localparam int SUM_W        = sum_width(WIDTH),
    localparam int CNT_W        = cnt_width(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    input  logic [SUM_W-1:0] sum_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [WIDTH-1:0] fail_a_o,
    output logic [WIDTH-1:0] fail_b_o,
    output logic [SUM_W-1:0] fail_sum_o
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;
    logic [SUM_W-1:0] fail_sum_q, fail_sum_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             gen_clr;
    logic             gen_adv;
    logic             last_vec;
    logic [SUM_W-1:0] expected_sum;
    logic             mismatch;

    rca_bist_opgen #(.WIDTH(WIDTH)) u_opgen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (gen_clr),
        .adv_i  (gen_adv),
        .a_o    (a_o),
        .b_o    (b_o),
        .last_o (last_vec)
    );

    assign expected_sum = {1'b0, a_o} + {1'b0, b_o};
    assign mismatch     = (sum_i != expected_sum);

    // Sweep sequencing; the operand generator is cleared whenever the sweep leaves SETTLE/CHECK
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        err_d      = err_q;
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        fail_sum_d = fail_sum_q;
        gen_clr    = 1'b0;
        gen_adv    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d    = ST_SETTLE;
                    settle_d   = 8'd0;
                    err_d      = '0;
                    fail_a_d   = '0;
                    fail_b_d   = '0;
                    fail_sum_d = '0;
                    gen_clr    = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SETTLE: begin
                if (abort_i) begin
                    state_d  = ST_IDLE;
                    settle_d = 8'd0;
                    gen_clr  = 1'b1;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_CHECK;
                    settle_d = 8'd0;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    gen_clr = 1'b1;
                end else begin
                    // err_q cannot wrap, so zero means no mismatch yet this sweep
                    if (mismatch) begin
                        if (err_q == '0) begin
                            fail_a_d   = a_o;
                            fail_b_d   = b_o;
                            fail_sum_d = sum_i;
                        end else begin
                            fail_a_d   = fail_a_q;
                        end
                        if (&err_q) begin
                            err_d = err_q;
                        end else begin
                            err_d = err_q + CNT_W'(1);
                        end
                    end else begin
                        err_d = err_q;
                    end
                    if (last_vec) begin
                        state_d = ST_DONE;
                        gen_clr = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                        gen_adv = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gen_clr = 1'b1;
            end
        endcase
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == '0);
    end

    // State and registered status outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            settle_q   <= 8'd0;
            err_q      <= '0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_sum_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
            fail_sum_q <= fail_sum_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_a_o    = fail_a_q;
    assign fail_b_o    = fail_b_q;
    assign fail_sum_o  = fail_sum_q;

endmodule

// File: tb/tb_rca_bist.sv
// Directed bench: a 4-bit BIST with a fault-injectable adder model and a 2-bit BIST with SETTLE_CYCLES=3.
module tb_rca_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start4, abort4, start2, abort2;
    int   checks   = 0;
    int   failures = 0;
    int   fault4   = 0;

    logic [3:0] a4, b4, fa4, fb4;
    logic [4:0] sum4, raw4, fs4;
    logic [8:0] err4;
    logic       busy4, done4, pass4;

    logic [1:0] a2, b2, fa2, fb2;
    logic [2:0] sum2, fs2;
    logic [4:0] err2;
    logic       busy2, done2, pass2;

    // Adder models: fault4 1 = sum[4] stuck at 0, 2 = sum[0] stuck at 1
    assign raw4 = {1'b0, a4} + {1'b0, b4};
    always_comb begin
        case (fault4)
            1:       sum4 = {1'b0, raw4[3:0]};
            2:       sum4 = raw4 | 5'd1;
            default: sum4 = raw4;
        endcase
    end
    assign sum2 = {1'b0, a2} + {1'b0, b2};

    rca_bist #(.WIDTH(4), .SETTLE_CYCLES(1)) u4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .abort_i(abort4),
        .a_o(a4), .b_o(b4), .sum_i(sum4), .busy_o(busy4), .done_o(done4),
        .pass_o(pass4), .err_count_o(err4), .fail_a_o(fa4), .fail_b_o(fb4),
        .fail_sum_o(fs4)
    );

    rca_bist #(.WIDTH(2), .SETTLE_CYCLES(3)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .abort_i(abort2),
        .a_o(a2), .b_o(b2), .sum_i(sum2), .busy_o(busy2), .done_o(done2),
        .pass_o(pass2), .err_count_o(err2), .fail_a_o(fa2), .fail_b_o(fb2),
        .fail_sum_o(fs2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a 4-bit sweep and count edges until done_o, optionally pulsing start mid-sweep
    task automatic run4(input int pulse_at, output int edges);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        edges  = 0;
        while (done4 !== 1'b1 && edges < 2000) begin
            start4 = (edges == pulse_at);
            tick();
            edges++;
        end
        start4 = 1'b0;
    endtask

    initial begin
        int edges;
        int guard;
        rst = 1'b1; start4 = 1'b0; abort4 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset4", {a4, b4, busy4, done4, pass4, err4, fa4, fb4, fs4}, 64'd0);
        chk("reset2", {a2, b2, busy2, done2, pass2, err2, fa2, fb2, fs2}, 64'd0);

        // Good adder; stray start pulse must not disturb the sweep
        run4(100, edges);
        chk("good_edges", edges, 512);
        chk("good_status", {done4, pass4, busy4, err4, a4, b4}, {1'b1, 1'b1, 1'b0, 9'd0, 4'd0, 4'd0});
        repeat (2) tick();
        chk("done_hold", {done4, pass4, err4}, {1'b1, 1'b1, 9'd0});

        // sum[4] stuck at 0: 120 pairs carry out, first is (1,15)
        fault4 = 1;
        run4(-1, edges);
        chk("msb_edges", edges, 512);
        chk("msb_err", err4, 120);
        chk("msb_fail", {fa4, fb4, fs4}, {4'd1, 4'd15, 5'd0});
        chk("msb_pass", {done4, pass4}, {1'b1, 1'b0});

        // sum[0] stuck at 1: 128 even sums, first is (0,0)
        fault4 = 2;
        run4(-1, edges);
        chk("lsb_err", err4, 128);
        chk("lsb_fail", {fa4, fb4, fs4}, {4'd0, 4'd0, 5'd1});
        chk("lsb_pass", {done4, pass4}, {1'b1, 1'b0});

        // Abort in the CHECK cycle of (3,7): 27 earlier even sums, no increment for (3,7)
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        guard = 0;
        while (!(a4 == 4'd3 && b4 == 4'd7) && guard < 2000) begin
            tick();
            guard++;
        end
        chk("abort_reach", guard < 2000, 1'b1);
        tick();
        abort4 = 1'b1;
        tick();
        abort4 = 1'b0;
        chk("abort_state", {busy4, done4, pass4, a4, b4}, 64'd0);
        chk("abort_held", {err4, fa4, fb4, fs4}, {9'd27, 4'd0, 4'd0, 5'd1});
        repeat (5) tick();
        chk("abort_nodone", {done4, busy4, err4}, {1'b0, 1'b0, 9'd27});

        // Abort in IDLE is a no-op; start beats abort when both are high
        abort4 = 1'b1;
        tick();
        chk("abort_idle", {busy4, done4, err4}, {1'b0, 1'b0, 9'd27});
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        abort4 = 1'b0;
        chk("start_wins", {busy4, err4}, {1'b1, 9'd0});

        // Reset mid-sweep, then a full good sweep
        repeat (40) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_reset", {a4, b4, busy4, done4, pass4, err4, fa4, fb4, fs4}, 64'd0);
        fault4 = 0;
        run4(-1, edges);
        chk("post_reset_edges", edges, 512);
        chk("post_reset_pass", {done4, pass4, err4}, {1'b1, 1'b1, 9'd0});

        // 2-bit, 3 settle cycles: each pair held 4 edges, a outer
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int e = 0; e < 64; e++) begin
            logic [1:0] ea, eb;
            ea = 2'((e / 4) >> 2);
            eb = 2'((e / 4) & 3);
            chk($sformatf("w2_vec%0d", e), {a2, b2, busy2, done2}, {ea, eb, 1'b1, 1'b0});
            tick();
        end
        chk("w2_done", {done2, pass2, busy2, err2, a2, b2}, {1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 2'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
